mem_stage_param: RTL

MEM_STAGE_PARAM -- requirements
Module: mem_stage_param

---
 rtl/mem_stage_param_if.sv | 37 +++
 rtl/mem_stage_param.sv | 127 ++++++++++++
 2 files changed

// File: rtl/mem_stage_param_if.sv
// Signal bundle around the MEM pipeline stage: instruction fields in, registered results out.
// The stage uses the slave modport; whatever feeds it uses master.
interface mem_stage_param_if #(
   parameter int DATA_W = 32,
   parameter int WB_W   = 3,
   parameter int REG_W  = 5
);
   logic              valid_in;
   logic              stall;
   logic              flush;
   logic [4:0]        M;
   logic [WB_W-1:0]   WB;
   logic [DATA_W-1:0] Alu_result;
   logic [DATA_W-1:0] Dato2;
   logic [REG_W-1:0]  Direccion;
   logic [DATA_W-1:0] jump_address;

   logic [DATA_W-1:0] Read_data;
   logic [DATA_W-1:0] Alu_result_out;
   logic [WB_W-1:0]   WB_out;
   logic [REG_W-1:0]  Direccion_out;
   logic [DATA_W-1:0] jump_address_out;
   logic              valid_out;
   logic              misalign_out;

   modport master (
      output valid_in, stall, flush, M, WB, Alu_result, Dato2, Direccion, jump_address,
      input  Read_data, Alu_result_out, WB_out, Direccion_out, jump_address_out,
             valid_out, misalign_out
   );

   modport slave (
      input  valid_in, stall, flush, M, WB, Alu_result, Dato2, Direccion, jump_address,
      output Read_data, Alu_result_out, WB_out, Direccion_out, jump_address_out,
             valid_out, misalign_out
   );
endinterface

// File: rtl/mem_stage_param.sv
// MEM pipeline stage: little-endian byte/half/word data memory plus a one-cycle output buffer.
// Optional macro MEM_MISALIGN_TRAP_EN traps misaligned accesses instead of force-aligning them.
module mem_stage_param #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 256,
   parameter int WB_W   = 3,
   parameter int REG_W  = 5
) (
   input logic              clk,
   input logic              rst,
   mem_stage_param_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int NB = DATA_W / 8;

   // Handshake: valid_in marks a real instruction (0 = bubble). stall is backpressure:
   // while high the buffer holds and no store commits. flush squashes and beats stall;
   // rst beats both.

   logic [DATA_W-1:0] r_mem [DEPTH];

   logic [DATA_W-1:0] r_read_data;
   logic [DATA_W-1:0] r_alu_result;
   logic [WB_W-1:0]   r_wb;
   logic [REG_W-1:0]  r_direccion;
   logic [DATA_W-1:0] r_jump_address;
   logic              r_valid;
   logic              r_misalign;

   logic [1:0]        w_size;
   logic [AW-1:0]     w_idx;
   logic [1:0]        w_off;
   logic [DATA_W-1:0] w_old;
   logic [DATA_W-1:0] w_shift;
   logic [DATA_W-1:0] w_load;
   logic [DATA_W-1:0] w_read_data;
   logic [NB-1:0]     w_be;
   logic [DATA_W-1:0] w_wdata;
   logic              w_trap;
   logic              w_we;

   assign w_size  = bus.M[3:2];
   assign w_idx   = bus.Alu_result[AW+1:2];
   assign w_old   = r_mem[w_idx];
   assign w_shift = w_old >> {w_off, 3'b000};

`ifdef MEM_MISALIGN_TRAP_EN
   logic w_access;
   logic w_misalign;
   assign w_access   = bus.M[0] | bus.M[1];
   assign w_misalign = ((w_size == 2'b01) & bus.Alu_result[0]) |
                       (w_size[1] & (bus.Alu_result[1:0] != 2'b00));
   assign w_trap     = bus.valid_in & w_access & w_misalign;
`else
   assign w_trap = 1'b0;
`endif

   // Lane offset is forced aligned for half/word; a trapped access never uses it.
   always_comb begin
      w_off   = 2'b00;
      w_load  = w_old;
      w_be    = {NB{1'b1}};
      w_wdata = bus.Dato2;
      case (w_size)
         2'b00: begin
            w_off   = bus.Alu_result[1:0];
            w_load  = bus.M[4] ? {{(DATA_W-8){1'b0}}, w_shift[7:0]}
                               : {{(DATA_W-8){w_shift[7]}}, w_shift[7:0]};
            w_be    = NB'(1) << w_off;
            w_wdata = {NB{bus.Dato2[7:0]}};
         end
         2'b01: begin
            w_off   = {bus.Alu_result[1], 1'b0};
            w_load  = bus.M[4] ? {{(DATA_W-16){1'b0}}, w_shift[15:0]}
                               : {{(DATA_W-16){w_shift[15]}}, w_shift[15:0]};
            w_be    = NB'(3) << w_off;
            w_wdata = {(NB/2){bus.Dato2[15:0]}};
         end
         default: begin
            w_off   = 2'b00;
            w_load  = w_old;
            w_be    = {NB{1'b1}};
            w_wdata = bus.Dato2;
         end
      endcase
   end

   assign w_read_data = (bus.M[0] && !w_trap) ? w_load : '0;
   assign w_we        = bus.valid_in & bus.M[1] & ~bus.stall & ~bus.flush & ~rst & ~w_trap;

   // Memory has no reset; the buffer samples w_old before this edge's write lands.
   always_ff @(posedge clk) begin
      for (int b = 0; b < NB; b++) begin
         if (w_we && w_be[b]) begin
            r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         r_read_data    <= '0;
         r_alu_result   <= '0;
         r_wb           <= '0;
         r_direccion    <= '0;
         r_jump_address <= '0;
         r_valid        <= 1'b0;
         r_misalign     <= 1'b0;
      end else if (!bus.stall) begin
         r_read_data    <= w_read_data;
         r_alu_result   <= bus.Alu_result;
         r_wb           <= (bus.valid_in && !w_trap) ? bus.WB : '0;
         r_direccion    <= bus.Direccion;
         r_jump_address <= bus.jump_address;
         r_valid        <= bus.valid_in;
         r_misalign     <= w_trap;
      end
   end

   assign bus.Read_data        = r_read_data;
   assign bus.Alu_result_out   = r_alu_result;
   assign bus.WB_out           = r_wb;
   assign bus.Direccion_out    = r_direccion;
   assign bus.jump_address_out = r_jump_address;
   assign bus.valid_out        = r_valid;
   assign bus.misalign_out     = r_misalign;
endmodule
